// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation
//   Iterative inverse Ascon permutation p^-a on a 320-bit state, a = 0..MAX_ROUNDS.
//   Each inverse round is the inverse linear layer followed by the inverse S-box and
//   the round-constant XOR. The inverse linear layer is Sigma^63, because
//   Sigma^64 = identity. It takes 63/LIN_UNROLL cycles, and the S-box takes one cycle.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready only when idle and out of reset
//   state_in           x0=[319:256] x1=[255:192] x2=[191:128] x3=[127:64] x4=[63:0]
//   rounds_in          round count a; values above MAX_ROUNDS are clamped
//   out_valid/out_ready result handshake; the result is held until accepted
//   state_out          result, same packing as state_in
//   busy               high while in the LIN or SBOX phase
module ascon_inv_permutation #(
  parameter int LIN_UNROLL = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] state_in,
  input  logic [3:0]   rounds_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  localparam int STEPS = 63 / LIN_UNROLL;

  // Only divisors of 63 land exactly on Sigma^63.
  if (!(LIN_UNROLL == 1 || LIN_UNROLL == 3 || LIN_UNROLL == 7 ||
        LIN_UNROLL == 9 || LIN_UNROLL == 21 || LIN_UNROLL == 63)) begin : g_bad_unroll
    $error("LIN_UNROLL must be one of 1,3,7,9,21,63");
  end
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 12) begin : g_bad_rounds
    $error("MAX_ROUNDS must be 1..12");
  end

  typedef enum logic [1:0] {S_IDLE, S_LIN, S_SBOX, S_DONE} state_t;

  state_t         r_fsm;
  logic [319:0]   r_state;
  logic [3:0]     r_round;
  logic [3:0]     r_last;
  logic [5:0]     r_step;
  logic           r_out_valid;

  logic [319:0]   w_lin;
  logic [319:0]   w_sbox;
  logic [3:0]     w_a;

  function automatic logic [63:0] ror64(input logic [63:0] w, input int unsigned n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] w, input int unsigned p,
                                        input int unsigned q);
    return w ^ ror64(w, p) ^ ror64(w, q);
  endfunction

  function automatic logic [319:0] sigma5(input logic [319:0] s);
    return {sigma(s[319:256], 19, 28), sigma(s[255:192], 61, 39),
            sigma(s[191:128],  1,  6), sigma(s[127:64],  10, 17),
            sigma(s[63:0],      7, 41)};
  endfunction

  function automatic logic [4:0] inv_sbox5(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h14;  5'd1:  return 5'h1A;  5'd2:  return 5'h07;  5'd3:  return 5'h0D;
      5'd4:  return 5'h00;  5'd5:  return 5'h09;  5'd6:  return 5'h0E;  5'd7:  return 5'h12;
      5'd8:  return 5'h0A;  5'd9:  return 5'h06;  5'd10: return 5'h1D;  5'd11: return 5'h01;
      5'd12: return 5'h19;  5'd13: return 5'h15;  5'd14: return 5'h13;  5'd15: return 5'h1E;
      5'd16: return 5'h18;  5'd17: return 5'h16;  5'd18: return 5'h0B;  5'd19: return 5'h11;
      5'd20: return 5'h03;  5'd21: return 5'h05;  5'd22: return 5'h1C;  5'd23: return 5'h1F;
      5'd24: return 5'h17;  5'd25: return 5'h1B;  5'd26: return 5'h04;  5'd27: return 5'h08;
      5'd28: return 5'h0F;  5'd29: return 5'h0C;  5'd30: return 5'h10;  default: return 5'h02;
    endcase
  endfunction

  // Bit-column j gathers bit j of x0..x4, with x0 as the MSB of the S-box index.
  function automatic logic [319:0] inv_sbox_layer(input logic [319:0] s);
    logic [319:0] o;
    logic [4:0]   c;
    o = '0;
    for (int j = 0; j < 64; j++) begin
      c = inv_sbox5({s[256+j], s[192+j], s[128+j], s[64+j], s[j]});
      o[256+j] = c[4];
      o[192+j] = c[3];
      o[128+j] = c[2];
      o[64+j]  = c[1];
      o[j]     = c[0];
    end
    return o;
  endfunction

  always_comb begin
    w_lin = r_state;
    for (int k = 0; k < LIN_UNROLL; k++) w_lin = sigma5(w_lin);
  end

  // Round constant c_i = {15-i, i} = {~i, i}, which lands in x2[7:0].
  assign w_sbox = inv_sbox_layer(r_state) ^ {184'b0, ~r_round, r_round, 128'b0};
  assign w_a    = (rounds_in > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_round     <= '0;
      r_last      <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: if (in_valid) begin
          r_state <= state_in;
          r_round <= 4'(MAX_ROUNDS - 1);
          r_last  <= 4'(MAX_ROUNDS) - w_a;
          r_step  <= '0;
          r_fsm   <= (w_a == 4'd0) ? S_DONE : S_LIN;
        end
        S_LIN: begin
          r_state <= w_lin;
          if (r_step == 6'(STEPS - 1)) begin
            r_step <= '0;
            r_fsm  <= S_SBOX;
          end else begin
            r_step <= r_step + 6'd1;
          end
        end
        S_SBOX: begin
          r_state <= w_sbox;
          if (r_round == r_last) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_round <= r_round - 4'd1;
            r_fsm   <= S_LIN;
          end
        end
        S_DONE: begin
          // An a=0 job enters DONE with out_valid low and raises it one cycle later.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_fsm == S_IDLE);
  assign busy      = (r_fsm == S_LIN) || (r_fsm == S_SBOX);
  assign out_valid = r_out_valid;
  assign state_out = r_state;

endmodule

// File: tb/tb_ascon_inv_permutation.sv
module tb_ascon_inv_permutation;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [319:0] state_in  [3];
  logic [3:0]   rounds_in [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [319:0] state_out [3];
  logic         busy      [3];

  // The instances use LIN_UNROLL = 1, 7 and 63, at indexes 0, 1 and 2.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      ascon_inv_permutation #(
        .LIN_UNROLL(g == 0 ? 1 : (g == 1 ? 7 : 63)),
        .MAX_ROUNDS(12)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[g]), .in_ready(in_ready[g]),
        .state_in(state_in[g]), .rounds_in(rounds_in[g]),
        .out_valid(out_valid[g]), .out_ready(out_ready[g]),
        .state_out(state_out[g]), .busy(busy[g])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  logic [319:0] sb_q[$];

  // ---------------- reference model (forward Ascon) ----------------
  function automatic logic [63:0] ror(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [319:0] fwd_sbox_layer(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] fwd_lin(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [7:0] rc(input int i);
    return 8'(((15 - i) << 4) | i);
  endfunction

  function automatic logic [319:0] fwd_perm(input logic [319:0] s, input int a);
    for (int i = 12 - a; i < 12; i++) begin
      s[135:128] ^= rc(i);
      s = fwd_lin(fwd_sbox_layer(s));
    end
    return s;
  endfunction

  // Inverse S-box found by searching the forward bit-sliced S-box.
  function automatic logic [4:0] inv_s5(input logic [4:0] y);
    logic [319:0] t;
    logic [4:0]   v;
    for (int k = 0; k < 32; k++) begin
      v = 5'(k);
      t = fwd_sbox_layer({63'b0, v[4], 63'b0, v[3], 63'b0, v[2], 63'b0, v[1], 63'b0, v[0]});
      if ({t[256], t[192], t[128], t[64], t[0]} == y) return v;
    end
    return 5'h0;
  endfunction

  function automatic logic [319:0] inv_round(input logic [319:0] s, input int i);
    logic [319:0] o;
    logic [4:0]   c;
    for (int k = 0; k < 63; k++) s = fwd_lin(s);
    o = '0;
    for (int j = 0; j < 64; j++) begin
      c = inv_s5({s[256+j], s[192+j], s[128+j], s[64+j], s[j]});
      {o[256+j], o[192+j], o[128+j], o[64+j], o[j]} = c;
    end
    o[135:128] ^= rc(i);
    return o;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int d, input logic [319:0] st, input logic [3:0] a,
                      input logic [319:0] exp);
    state_in[d] = st; rounds_in[d] = a; in_valid[d] = 1'b1;
    sb_q.push_back(exp);
    tick();
    in_valid[d] = 1'b0;
    state_in[d] = ~st;  // must not affect the running job
  endtask

  task automatic wait_out(input int d, input int budget, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < budget) begin tick(); lat++; end
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1; tick(); out_ready[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]); end
      checks++; if (state_out[d] !== '0) begin failures++; $display("FAIL reset_state_out dut%0d got %h want 0", d, state_out[d]); end
      checks++; if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy[d]); end
      checks++; if (in_ready[d] !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low dut%0d got %b want 0", d, in_ready[d]); end
    end
    rst_n = 1'b1; #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_in_ready_high dut%0d got %b want 1", d, in_ready[d]); end
    end
  endtask

  task automatic test_inv_sbox();
    logic [319:0] y, exp, got;
    int lat;
    for (int k = 0; k < 64; k++) begin
      logic [4:0] v;
      v = 5'(k % 32);
      {y[256+k], y[192+k], y[128+k], y[64+k], y[k]} = v;
    end
    send(2, y, 4'd1, inv_round(y, 11));
    wait_out(2, 10, lat);
    exp = sb_q.pop_front(); got = state_out[2];
    checks++; if (lat !== 2) begin failures++; $display("FAIL sbox_latency got %0d want 2", lat); end
    checks++; if (got !== exp) begin failures++; $display("FAIL sbox_result got %h want %h", got, exp); end
    take(2);
  endtask

  task automatic test_round_trip();
    logic [319:0] x, exp, got;
    int lat, d, want;
    for (int t = 0; t < 4; t++) begin
      d = (t < 2) ? 0 : 2;
      want = (d == 0) ? 768 : 24;
      x = (t % 2 == 0) ? 320'h0 : {5{64'h0123456789ABCDEF}};
      checks++; if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL rt_in_ready dut%0d got %b want 1", d, in_ready[d]); end
      send(d, fwd_perm(x, 12), 4'd12, x);
      wait_out(d, 1000, lat);
      exp = sb_q.pop_front(); got = state_out[d];
      checks++; if (lat !== want) begin failures++; $display("FAIL rt_latency dut%0d got %0d want %0d", d, lat, want); end
      checks++; if (got !== exp) begin failures++; $display("FAIL rt_result dut%0d got %h want %h", d, got, exp); end
      take(d);
    end
  endtask

  task automatic test_latency();
    logic [319:0] x, exp, got;
    int lat;
    x = rand320();
    send(1, fwd_perm(x, 6), 4'd6, x);
    checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL lat_busy got %b want 1", busy[1]); end
    wait_out(1, 200, lat);
    exp = sb_q.pop_front(); got = state_out[1];
    checks++; if (lat !== 60) begin failures++; $display("FAIL lat_u7_a6 got %0d want 60", lat); end
    checks++; if (got !== exp) begin failures++; $display("FAIL lat_result got %h want %h", got, exp); end
    take(1);
  endtask

  task automatic test_a0_clamp();
    logic [319:0] x, exp, got;
    int lat;
    x = rand320();
    send(1, x, 4'd0, x);
    wait_out(1, 20, lat);
    exp = sb_q.pop_front(); got = state_out[1];
    checks++; if (lat !== 1) begin failures++; $display("FAIL a0_latency got %0d want 1", lat); end
    checks++; if (got !== exp) begin failures++; $display("FAIL a0_result got %h want %h", got, exp); end
    take(1);
    x = rand320();
    send(1, fwd_perm(x, 12), 4'd15, x);
    wait_out(1, 300, lat);
    exp = sb_q.pop_front(); got = state_out[1];
    checks++; if (lat !== 120) begin failures++; $display("FAIL clamp_latency got %0d want 120", lat); end
    checks++; if (got !== exp) begin failures++; $display("FAIL clamp_result got %h want %h", got, exp); end
    take(1);
  endtask

  task automatic test_back_to_back();
    logic [319:0] x, exp, held;
    int lat;
    x = rand320();
    send(1, fwd_perm(x, 2), 4'd2, x);
    wait_out(1, 100, lat);
    exp = sb_q.pop_front(); held = state_out[1];
    checks++; if (held !== exp) begin failures++; $display("FAIL bp_result got %h want %h", held, exp); end
    // Hold the result with out_ready low and offer a competing input.
    state_in[1] = rand320(); rounds_in[1] = 4'd1; in_valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (out_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc%0d got %b want 1", c, out_valid[1]); end
      checks++; if (state_out[1] !== exp) begin failures++; $display("FAIL bp_state_stable cyc%0d got %h want %h", c, state_out[1], exp); end
      checks++; if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready[1]); end
    end
    in_valid[1] = 1'b0;
    take(1);
    checks++; if (out_valid[1] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got %b want 0", out_valid[1]); end
    checks++; if (in_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got %b want 1", in_ready[1]); end
    x = rand320();
    send(1, fwd_perm(x, 3), 4'd3, x);
    wait_out(1, 100, lat);
    exp = sb_q.pop_front();
    checks++; if (lat !== 30) begin failures++; $display("FAIL b2b_latency got %0d want 30", lat); end
    checks++; if (state_out[1] !== exp) begin failures++; $display("FAIL b2b_result got %h want %h", state_out[1], exp); end
    take(1);
  endtask

  task automatic test_reset_midrun();
    logic [319:0] x, exp;
    int lat;
    x = rand320();
    send(0, fwd_perm(x, 12), 4'd12, x);
    for (int c = 1; c < 100; c++) tick();
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %b want 1", busy[0]); end
    rst_n = 1'b0;
    tick();
    void'(sb_q.pop_front());
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL mid_out_valid got %b want 0", out_valid[0]); end
    checks++; if (state_out[0] !== '0) begin failures++; $display("FAIL mid_state_out got %h want 0", state_out[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL mid_busy got %b want 0", busy[0]); end
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL mid_in_ready_low got %b want 0", in_ready[0]); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL mid_in_ready_high got %b want 1", in_ready[0]); end
    x = rand320();
    send(0, fwd_perm(x, 3), 4'd3, x);
    wait_out(0, 400, lat);
    exp = sb_q.pop_front();
    checks++; if (lat !== 192) begin failures++; $display("FAIL mid_new_latency got %0d want 192", lat); end
    checks++; if (state_out[0] !== exp) begin failures++; $display("FAIL mid_new_result got %h want %h", state_out[0], exp); end
    take(0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; state_in[d] = '0; rounds_in[d] = '0;
    end
    test_reset();
    test_inv_sbox();
    test_round_trip();
    test_latency();
    test_a0_clamp();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
